// File: rtl/demux_stream_router_if.sv
// Stream-router bus: one upstream valid/ready port, N_CH downstream valid/ready slots,
// plus the routing controls and status. The router connects through the slave modport.
interface demux_stream_router_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 1
);
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [DATA_W-1:0]      in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [SEL_W-1:0]       sel;
  logic [1:0]             mode;
  logic [N_CH*DATA_W-1:0] out_data;
  logic [N_CH-1:0]        out_valid;
  logic [N_CH-1:0]        out_ready;
  logic [SEL_W-1:0]       scan_ch;
  logic                   drop_err;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_valid, scan_ch, drop_err
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_valid, scan_ch, drop_err
  );
endinterface

// File: rtl/demux_stream_router.sv
// 1-to-N_CH stream demultiplexer with per-channel registered valid/ready slots.
// Routing is DIRECT (sel), SCAN (rotating pointer) or BROADCAST (all channels).
module demux_stream_router #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_stream_router_if.slave  bus
);
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_BCAST  = 2'b10;

  logic [N_CH-1:0]        valid_q, valid_d;
  logic [N_CH*DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]       scan_q, scan_d;
  logic                   drop_q, drop_d;

  logic [N_CH-1:0]        free_s;
  logic [N_CH-1:0]        drain_s;
  logic [N_CH-1:0]        tgt_s;
  logic                   ready_s;
  logic                   accept_s;

  assign free_s  = ~valid_q | bus.out_ready;
  assign drain_s =  valid_q & bus.out_ready;

  // Target set and upstream ready; an empty DIRECT target (sel out of range) acts as a sink
  always_comb begin
    tgt_s   = '0;
    ready_s = 1'b0;
    case (bus.mode)
      MODE_DIRECT: begin
        for (int i = 0; i < N_CH; i++) begin
          if (int'(bus.sel) == i) begin
            tgt_s[i] = 1'b1;
          end else begin
            tgt_s[i] = 1'b0;
          end
        end
        ready_s = &(free_s | ~tgt_s);
      end
      MODE_SCAN: begin
        for (int i = 0; i < N_CH; i++) begin
          if (int'(scan_q) == i) begin
            tgt_s[i] = 1'b1;
          end else begin
            tgt_s[i] = 1'b0;
          end
        end
        ready_s = &(free_s | ~tgt_s);
      end
      MODE_BCAST: begin
        tgt_s   = '1;
        ready_s = &free_s;
      end
      default: begin
        tgt_s   = '0;
        ready_s = 1'b0;
      end
    endcase
  end

  assign accept_s = bus.in_valid & ready_s;

  // Next state of the output slots, scan pointer and drop pulse
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    scan_d  = scan_q;
    drop_d  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (accept_s && tgt_s[i]) begin
        valid_d[i]                  = 1'b1;
        data_d[i*DATA_W +: DATA_W]  = bus.in_data;
      end else if (drain_s[i]) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_q[i];
      end
    end
    if (accept_s && (bus.mode == MODE_SCAN)) begin
      if (scan_q == SEL_W'(N_CH - 1)) begin
        scan_d = '0;
      end else begin
        scan_d = scan_q + SEL_W'(1);
      end
    end else begin
      scan_d = scan_q;
    end
    if (accept_s && (bus.mode == MODE_DIRECT) && (tgt_s == '0)) begin
      drop_d = 1'b1;
    end else begin
      drop_d = 1'b0;
    end
  end

  // State registers; reset discards any pending output words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      scan_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      scan_q  <= scan_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.scan_ch   = scan_q;
  assign bus.drop_err  = drop_q;
endmodule

// File: tb/tb_demux_stream_router.sv
// Bench for demux_stream_router: directed vectors on a 4-channel and a 3-channel instance,
// with a per-channel expected-word queue drained by an independent output monitor.
module tb_demux_stream_router;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   m_scan;

  logic [7:0] exp_q [4][$];

  demux_stream_router_if #(.N_CH(4), .DATA_W(8)) if4 ();
  demux_stream_router_if #(.N_CH(3), .DATA_W(8)) if3 ();

  demux_stream_router #(.N_CH(4), .DATA_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  demux_stream_router #(.N_CH(3), .DATA_W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every word drained from a channel must match the oldest expected word there
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (if4.out_valid[i] && if4.out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("unexpected_word_ch%0d", i), {56'd0, if4.out_data[i*8 +: 8]}, 64'hFFFF);
          end else begin
            chk($sformatf("drain_ch%0d", i), {56'd0, if4.out_data[i*8 +: 8]}, {56'd0, exp_q[i].pop_front()});
          end
        end
      end
    end
  end

  task automatic push_expected(input logic [1:0] m, input logic [1:0] s, input logic [7:0] d);
    case (m)
      2'b00: exp_q[s].push_back(d);
      2'b01: begin
        exp_q[m_scan].push_back(d);
        m_scan = (m_scan == 3) ? 0 : m_scan + 1;
      end
      2'b10: for (int i = 0; i < 4; i++) exp_q[i].push_back(d);
      default: ;
    endcase
  endtask

  // Present one word and wait (bounded) for acceptance; call just after a rising edge
  task automatic send(input logic [1:0] m, input logic [1:0] s, input logic [7:0] d);
    int n;
    if4.mode = m; if4.sel = s; if4.in_data = d; if4.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!if4.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!if4.in_ready) begin
      chk("send_timeout", 64'd0, 64'd1);
      if4.in_valid = 1'b0;
    end else begin
      push_expected(m, s, d);
      @(posedge clk); #1;
      if4.in_valid = 1'b0;
    end
  endtask

  initial begin
    checks = 0; failures = 0; m_scan = 0;
    rst_n = 1'b0;
    if4.in_data = 8'h00; if4.in_valid = 1'b0; if4.sel = 2'd0; if4.mode = 2'b00; if4.out_ready = 4'hF;
    if3.in_data = 8'h00; if3.in_valid = 1'b0; if3.sel = 2'd0; if3.mode = 2'b00; if3.out_ready = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {60'd0, if4.out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, if4.out_data}, 64'd0);
    chk("rst_scan_ch", {62'd0, if4.scan_ch}, 64'd0);
    chk("rst_drop_err", {63'd0, if4.drop_err}, 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // DIRECT single word
    send(2'b00, 2'd2, 8'hA5);
    chk("direct_out_valid", {60'd0, if4.out_valid}, 64'h4);
    chk("direct_out_data", {32'd0, if4.out_data}, 64'h00A5_0000);

    // Backpressure on channel 1
    if4.out_ready = 4'b1101;
    send(2'b00, 2'd1, 8'h11);
    if4.mode = 2'b00; if4.sel = 2'd1; if4.in_data = 8'h22; if4.in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_low", {63'd0, if4.in_ready}, 64'd0);
    chk("bp_ch1_held", {56'd0, if4.out_data[15:8]}, 64'h11);
    @(posedge clk); #1;
    chk("bp_in_ready_still_low", {63'd0, if4.in_ready}, 64'd0);
    if4.out_ready = 4'hF;
    #1;
    chk("bp_in_ready_rise", {63'd0, if4.in_ready}, 64'd1);
    exp_q[1].push_back(8'h22);
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    chk("bp_ch1_second", {56'd0, if4.out_data[15:8]}, 64'h22);
    chk("bp_ch1_valid", {63'd0, if4.out_valid[1]}, 64'd1);

    // SCAN six words
    for (int k = 1; k <= 6; k++) send(2'b01, 2'd0, 8'(k));
    chk("scan_ptr_end", {62'd0, if4.scan_ch}, 64'd2);
    chk("scan_ch1_last", {56'd0, if4.out_data[15:8]}, 64'h06);

    // BROADCAST blocked by one busy channel
    if4.out_ready = 4'b1011;
    send(2'b00, 2'd2, 8'h3C);
    if4.mode = 2'b10; if4.in_data = 8'h5A; if4.in_valid = 1'b1;
    @(negedge clk);
    chk("bcast_in_ready_low", {63'd0, if4.in_ready}, 64'd0);
    @(posedge clk); #1;
    if4.out_ready = 4'hF;
    @(negedge clk);
    chk("bcast_in_ready_high", {63'd0, if4.in_ready}, 64'd1);
    push_expected(2'b10, 2'd0, 8'h5A);
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    chk("bcast_out_valid", {60'd0, if4.out_valid}, 64'hF);
    chk("bcast_out_data", {32'd0, if4.out_data}, 64'h5A5A_5A5A);
    chk("bcast_scan_hold", {62'd0, if4.scan_ch}, 64'd2);
    @(posedge clk); #1;

    // N_CH=3: out-of-range sink and reserved mode
    if3.mode = 2'b00; if3.sel = 2'd3; if3.in_data = 8'h01; if3.in_valid = 1'b1;
    @(negedge clk);
    chk("n3_sink_in_ready", {63'd0, if3.in_ready}, 64'd1);
    @(posedge clk); #1;
    if3.in_valid = 1'b0;
    chk("n3_drop_err_pulse", {63'd0, if3.drop_err}, 64'd1);
    chk("n3_out_valid", {61'd0, if3.out_valid}, 64'd0);
    @(posedge clk); #1;
    chk("n3_drop_err_clear", {63'd0, if3.drop_err}, 64'd0);
    if3.mode = 2'b11; if3.sel = 2'd0;
    #1;
    chk("n3_reserved_in_ready", {63'd0, if3.in_ready}, 64'd0);

    // Asynchronous reset with a word pending
    if4.out_ready = 4'h0;
    send(2'b00, 2'd3, 8'h77);
    chk("pend_out_valid", {60'd0, if4.out_valid}, 64'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {60'd0, if4.out_valid}, 64'd0);
    chk("async_rst_out_data", {32'd0, if4.out_data}, 64'd0);
    chk("async_rst_scan_ch", {62'd0, if4.scan_ch}, 64'd0);
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    m_scan = 0;
    @(posedge clk); #2 rst_n = 1'b1;
    if4.out_ready = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("queue_empty_ch%0d", i), 64'(exp_q[i].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
